// File: rtl/dram_lsu.sv
// rtl/dram_lsu.sv - byte/half/word load-store unit driving RAM port A with read-modify-write
// Option DRAM_LSU_SIGNEXT_EN: honour the sign input on byte/half loads.
module dram_lsu #(
   parameter int BA_W = 14
) (
   input  logic            clk_a,
   input  logic            reset,
   input  logic            req,
   input  logic            we,
   input  logic [1:0]      size,
   input  logic            sign,
   input  logic [BA_W-1:0] addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            ready,
   output logic            misalign,
   output logic            busy,
   output logic [BA_W-3:0] ram_addr,
   output logic [31:0]     ram_data,
   output logic            ram_we,
   input  logic [31:0]     ram_q
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR, S_DONE} state_t;

   state_t      state;
   logic        we_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic        illegal;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        fill_b;
   logic        fill_h;
   logic [31:0] ld_val;
   logic [31:0] merged;

`ifdef DRAM_LSU_SIGNEXT_EN
   logic        sign_q;
`else
   logic        unused_sign;
   assign unused_sign = sign;
`endif

   always_comb begin
      illegal = (size == 2'b11) ||
                (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
   end

   // Lane extraction and merge both work on the registered RAM output seen in MRG.
   always_comb begin
      ld_byte = ram_q[{lane_q, 3'b000} +: 8];
      ld_half = ram_q[{lane_q[1], 4'b0000} +: 16];
`ifdef DRAM_LSU_SIGNEXT_EN
      fill_b  = sign_q & ld_byte[7];
      fill_h  = sign_q & ld_half[15];
`else
      fill_b  = 1'b0;
      fill_h  = 1'b0;
`endif
      case (size_q)
         2'b00:   ld_val = {{24{fill_b}}, ld_byte};
         2'b01:   ld_val = {{16{fill_h}}, ld_half};
         default: ld_val = ram_q;
      endcase
      merged = ram_q;
      case (size_q)
         2'b00:   merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
         2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_ff @(posedge clk_a) begin
      if (reset) begin
         state    <= S_IDLE;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         lane_q   <= 2'b00;
         wdata_q  <= 32'd0;
`ifdef DRAM_LSU_SIGNEXT_EN
         sign_q   <= 1'b0;
`endif
         rdata    <= 32'd0;
         ready    <= 1'b0;
         misalign <= 1'b0;
         busy     <= 1'b0;
         ram_addr <= '0;
         ram_data <= 32'd0;
         ram_we   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  we_q    <= we;
                  size_q  <= size;
                  lane_q  <= addr[1:0];
                  wdata_q <= wdata;
`ifdef DRAM_LSU_SIGNEXT_EN
                  sign_q  <= sign;
`endif
                  busy    <= 1'b1;
                  if (illegal) begin
                     rdata    <= 32'd0;
                     ready    <= 1'b1;
                     misalign <= 1'b1;
                     state    <= S_DONE;
                  end else if (we && size == 2'b10) begin
                     ram_addr <= addr[BA_W-1:2];
                     ram_data <= wdata;
                     ram_we   <= 1'b1;
                     state    <= S_WR;
                  end else begin
                     ram_addr <= addr[BA_W-1:2];
                     state    <= S_RD;
                  end
               end
            end
            S_RD: state <= S_MRG;
            S_MRG: begin
               if (we_q) begin
                  ram_data <= merged;
                  ram_we   <= 1'b1;
                  state    <= S_WR;
               end else begin
                  rdata <= ld_val;
                  ready <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_WR: begin
               ram_we <= 1'b0;
               rdata  <= 32'd0;
               ready  <= 1'b1;
               state  <= S_DONE;
            end
            default: begin
               ready    <= 1'b0;
               misalign <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_lsu.sv
// tb/tb_dram_lsu.sv - scoreboard bench for dram_lsu with a behavioural RAM on port A
// Expectations follow DRAM_LSU_SIGNEXT_EN when the bench is built with it.
module tb_dram_lsu;

   logic        clk_a = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign = 1'b0;
   logic [13:0] addr = 14'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        ready;
   logic        misalign;
   logic        busy;
   logic [11:0] ram_addr;
   logic [31:0] ram_data;
   logic        ram_we;
   logic [31:0] ram_q = 32'd0;

   logic [31:0] mem     [4096];
   logic [31:0] ref_mem [4096];

   typedef struct {logic [31:0] rdata; logic mis; int lat; int t;} rsp_t;
   typedef struct {logic [11:0] a; logic [31:0] d; int lat; int t;} wr_t;
   rsp_t rsp_q[$];
   wr_t  wr_q[$];
   rsp_t mon_r;
   wr_t  mon_w;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   dram_lsu #(.BA_W(14)) dut (
      .clk_a(clk_a), .reset(reset), .req(req), .we(we), .size(size), .sign(sign),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .misalign(misalign),
      .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
   );

   always #5 clk_a = ~clk_a;
   always @(posedge clk_a) cyc <= cyc + 1;

   always @(posedge clk_a) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_q <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk_a) begin
      if (!reset) begin
         if (ready) begin
            if (rsp_q.size() == 0) check("spurious_ready", 32'd1, 32'd0);
            else begin
               mon_r = rsp_q.pop_front();
               check("rdata", rdata, mon_r.rdata);
               check("misalign", {31'd0, misalign}, {31'd0, mon_r.mis});
               check("ready_latency", cyc - mon_r.t, mon_r.lat);
               check("busy_at_ready", {31'd0, busy}, 32'd1);
            end
         end
         if (ram_we) begin
            if (wr_q.size() == 0) check("spurious_ram_we", 32'd1, 32'd0);
            else begin
               mon_w = wr_q.pop_front();
               check("ram_addr", {20'd0, ram_addr}, {20'd0, mon_w.a});
               check("ram_data", ram_data, mon_w.d);
               check("we_latency", cyc - mon_w.t, mon_w.lat);
            end
         end
      end
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [13:0] a,
                        input logic [31:0] wd, input bit hold, input bit expect_en);
      int n = 0;
      int sh;
      logic [31:0] old, val, mask;
      rsp_t r;
      wr_t x;
      @(negedge clk_a);
      while (busy && n < 60) begin
         @(negedge clk_a);
         n++;
      end
      if (busy) check("issue_timeout", 32'd1, 32'd0);
      req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
      sh = 8 * int'(a[1:0]);
      old = ref_mem[a[13:2]];
      r.t = cyc; r.rdata = 32'd0; r.mis = 1'b0;
      x.t = cyc; x.a = a[13:2]; x.d = 32'd0; x.lat = 0;
      if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) begin
         r.mis = 1'b1; r.lat = 1;
      end else if (w) begin
         if (sz == 2'b10) begin
            x.d = wd; x.lat = 1; r.lat = 2;
         end else begin
            mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
            x.d = (old & ~mask) | ((wd << sh) & mask);
            x.lat = 3; r.lat = 4;
         end
         if (expect_en) begin
            wr_q.push_back(x);
            ref_mem[a[13:2]] = x.d;
         end
      end else begin
         val = old >> sh;
         if (sz == 2'b00) begin
            val = val & 32'h0000_00FF;
`ifdef DRAM_LSU_SIGNEXT_EN
            if (sg && val[7]) val = val | 32'hFFFF_FF00;
`endif
         end else if (sz == 2'b01) begin
            val = val & 32'h0000_FFFF;
`ifdef DRAM_LSU_SIGNEXT_EN
            if (sg && val[15]) val = val | 32'hFFFF_0000;
`endif
         end
         r.rdata = val; r.lat = 3;
      end
      if (expect_en) rsp_q.push_back(r);
      @(posedge clk_a);
      #1;
      if (!hold) req = 1'b0;
   endtask

   initial begin
      int n;
      logic [1:0] sz;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      repeat (3) @(posedge clk_a);
      @(negedge clk_a);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
      check("rst_ram_data", ram_data, 32'd0);
      check("rst_ram_we", {31'd0, ram_we}, 32'd0);
      reset = 1'b0;

      issue(1'b1, 2'b10, 1'b0, 14'h040, 32'hDEADBEEF, 1'b0, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 14'h040, 32'd0, 1'b0, 1'b1);
      issue(1'b1, 2'b10, 1'b0, 14'h040, 32'h8899AABB, 1'b0, 1'b1);
      issue(1'b1, 2'b00, 1'b0, 14'h041, 32'h00000012, 1'b0, 1'b1);
      issue(1'b0, 2'b00, 1'b1, 14'h043, 32'd0, 1'b0, 1'b1);
      issue(1'b0, 2'b00, 1'b0, 14'h043, 32'd0, 1'b0, 1'b1);
      issue(1'b0, 2'b01, 1'b1, 14'h042, 32'd0, 1'b0, 1'b1);
      issue(1'b0, 2'b00, 1'b1, 14'h041, 32'd0, 1'b0, 1'b1);
      issue(1'b0, 2'b01, 1'b0, 14'h041, 32'd0, 1'b0, 1'b1);
      issue(1'b1, 2'b11, 1'b0, 14'h040, 32'h12345678, 1'b0, 1'b1);
      issue(1'b1, 2'b10, 1'b0, 14'h042, 32'h12345678, 1'b0, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 14'h040, 32'd0, 1'b0, 1'b1);

      issue(1'b1, 2'b10, 1'b0, 14'h044, 32'hCAFEF00D, 1'b0, 1'b1);
      issue(1'b1, 2'b01, 1'b0, 14'h046, 32'h00005555, 1'b0, 1'b0);
      @(negedge clk_a);
      reset = 1'b1;
      @(negedge clk_a);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ready", {31'd0, ready}, 32'd0);
      check("abort_ram_we", {31'd0, ram_we}, 32'd0);
      check("abort_ram_addr", {20'd0, ram_addr}, 32'd0);
      check("abort_ram_data", ram_data, 32'd0);
      check("abort_rdata", rdata, 32'd0);
      reset = 1'b0;
      @(negedge clk_a);
      check("abort_mem", mem[12'h011], 32'hCAFEF00D);
      issue(1'b1, 2'b01, 1'b0, 14'h046, 32'h00005555, 1'b0, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 14'h044, 32'd0, 1'b0, 1'b1);

      for (int i = 0; i < 8; i++) begin
         sz = (i % 3 == 0) ? 2'b10 : ((i % 3 == 1) ? 2'b00 : 2'b01);
         issue(i[0], sz, 1'b1, 14'h048 + 14'(i & 2) + ((sz == 2'b00) ? 14'(i & 1) : 14'd0),
               $urandom, 1'b1, 1'b1);
      end
      req = 1'b0;

      for (int i = 0; i < 30; i++) begin
         issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               14'h050 + 14'($urandom_range(0, 15)), $urandom, 1'b0, 1'b1);
      end

      n = 0;
      while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
         @(negedge clk_a);
         n++;
      end
      check("drain_rsp", rsp_q.size(), 32'd0);
      check("drain_wr", wr_q.size(), 32'd0);
      check("final_mem_040", mem[12'h010], ref_mem[12'h010]);
      check("final_mem_044", mem[12'h011], ref_mem[12'h011]);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
